// File: rtl/pmem_burst_adaptor_if.sv
// Cache-side line request/response signals and memory-side beat bus of pmem_burst_adaptor.
// slave is the adaptor's view; master is the view of the caches and memory around it.
interface pmem_burst_adaptor_if #(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64,
  parameter int ADDR_WIDTH = 32
);
  logic                  i_pmem_read;
  logic [ADDR_WIDTH-1:0] i_pmem_address;
  logic [LINE_WIDTH-1:0] i_pmem_rdata;
  logic                  i_pmem_resp;

  logic                  d_pmem_read;
  logic                  d_pmem_write;
  logic [ADDR_WIDTH-1:0] d_pmem_address;
  logic [LINE_WIDTH-1:0] d_pmem_wdata;
  logic [LINE_WIDTH-1:0] d_pmem_rdata;
  logic                  d_pmem_resp;

  logic                  burst_read;
  logic                  burst_write;
  logic [ADDR_WIDTH-1:0] burst_address;
  logic [BEAT_WIDTH-1:0] burst_wdata;
  logic [BEAT_WIDTH-1:0] burst_rdata;
  logic                  burst_resp;

  modport slave (
    input  i_pmem_read, i_pmem_address,
    output i_pmem_rdata, i_pmem_resp,
    input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    output d_pmem_rdata, d_pmem_resp,
    output burst_read, burst_write, burst_address, burst_wdata,
    input  burst_rdata, burst_resp
  );

  modport master (
    output i_pmem_read, i_pmem_address,
    input  i_pmem_rdata, i_pmem_resp,
    output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    input  d_pmem_rdata, d_pmem_resp,
    input  burst_read, burst_write, burst_address, burst_wdata,
    output burst_rdata, burst_resp
  );
endinterface

// File: rtl/pmem_burst_adaptor.sv
// Arbitrates I-cache and D-cache line requests (D-cache first) and turns each granted
// line into a BEATS-long burst on the memory bus, answering with a one-cycle resp.
module pmem_burst_adaptor #(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64,
  parameter int ADDR_WIDTH = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  pmem_burst_adaptor_if.slave bus
);
  localparam int BEATS    = LINE_WIDTH / BEAT_WIDTH;
  localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFFSET_W = $clog2(LINE_WIDTH / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

  state_t                state;
  logic                  client_d;
  logic [CNT_W-1:0]      beat;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] line_q;
  logic [LINE_WIDTH-1:0] i_rdata_q;
  logic [LINE_WIDTH-1:0] d_rdata_q;
  logic [LINE_WIDTH-1:0] merged_line;
  logic                  last_beat;

  function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] a);
    return {a[ADDR_WIDTH-1:OFFSET_W], OFFSET_W'(0)};
  endfunction

  assign last_beat = (beat == LAST_BEAT);

  // Line buffer with the incoming read beat dropped into the current slot.
  always_comb begin
    merged_line = line_q;
    merged_line[int'(beat)*BEAT_WIDTH +: BEAT_WIDTH] = bus.burst_rdata;
  end

  // line_q doubles as the write-back source and the read assembly buffer; the client's
  // rdata register is only updated on the final beat so it keeps the last complete line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      client_d  <= 1'b0;
      beat      <= '0;
      addr_q    <= '0;
      line_q    <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          beat <= '0;
          if (bus.d_pmem_write || bus.d_pmem_read) begin
            client_d <= 1'b1;
            addr_q   <= line_align(bus.d_pmem_address);
            line_q   <= bus.d_pmem_wdata;
            state    <= bus.d_pmem_write ? WR_BURST : RD_BURST;
          end else if (bus.i_pmem_read) begin
            client_d <= 1'b0;
            addr_q   <= line_align(bus.i_pmem_address);
            state    <= RD_BURST;
          end
        end
        RD_BURST: begin
          if (bus.burst_resp) begin
            line_q <= merged_line;
            if (last_beat) begin
              beat  <= '0;
              state <= DONE;
              if (client_d) d_rdata_q <= merged_line;
              else          i_rdata_q <= merged_line;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        WR_BURST: begin
          if (bus.burst_resp) begin
            if (last_beat) begin
              beat  <= '0;
              state <= DONE;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.burst_read    = (state == RD_BURST);
  assign bus.burst_write   = (state == WR_BURST);
  assign bus.burst_address = addr_q;
  assign bus.burst_wdata   = (state == WR_BURST) ? line_q[int'(beat)*BEAT_WIDTH +: BEAT_WIDTH]
                                                 : '0;
  assign bus.i_pmem_resp   = (state == DONE) && !client_d;
  assign bus.d_pmem_resp   = (state == DONE) && client_d;
  assign bus.i_pmem_rdata  = i_rdata_q;
  assign bus.d_pmem_rdata  = d_rdata_q;
endmodule
